// File: rtl/alu_pkg.sv
// Shared ALU op-code constants and arbiter FSM state type.
// Op codes must match the encoding produced by the decode-side alu_op generation.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SLL  = 4'h1;
    localparam logic [3:0] ALU_SLT  = 4'h2;
    localparam logic [3:0] ALU_SLTU = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SRL  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_AND  = 4'h7;
    localparam logic [3:0] ALU_SUB  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'hD;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational XLEN-wide ALU shared by the execute stage and branch/address unit.
// Shifts are always logical; the SRA encoding is served by the logical right shift.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        // NOTE: default assignment first so every path drives result; no latch is inferred.
        result = '0;
        case (op)
            ALU_ADD:          result = a + b;
            ALU_SUB:          result = a - b;
            ALU_SLL:          result = a << shamt;
            ALU_SRL, ALU_SRA: result = a >> shamt;
            ALU_SLT:          result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:         result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:          result = a ^ b;
            ALU_OR:           result = a | b;
            ALU_AND:          result = a & b;
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-port arbiter in front of one shared ALU with a single registered result slot.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [3:0]      req_op0,
    input  logic [XLEN-1:0] req_a0,
    input  logic [XLEN-1:0] req_b0,
    input  logic [3:0]      req_op1,
    input  logic [XLEN-1:0] req_a1,
    input  logic [XLEN-1:0] req_b1,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero
);

    arb_state_e      state_q;
    logic            owner_q;
    logic [1:0]      rsp_valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
`ifdef ALU_ARB_RR_EN
    logic            rr_ptr_q;
`endif

    logic            slot_free;
    logic            gnt_valid;
    logic            gnt_port;
    logic [3:0]      sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic [XLEN-1:0] alu_result;

    // The slot frees in the same cycle the owner drains, allowing back-to-back grants.
    always_comb begin
        slot_free = (state_q == ST_IDLE) || rsp_ready[owner_q];
        gnt_port  = ~req_valid[0];
`ifdef ALU_ARB_RR_EN
        if (req_valid == 2'b11) begin
            gnt_port = rr_ptr_q;
        end
`endif
        gnt_valid = slot_free && (req_valid != 2'b00);
    end

    assign req_ready = (gnt_valid && rst_n) ? port_onehot(gnt_port) : 2'b00;

    assign sel_op = gnt_port ? req_op1 : req_op0;
    assign sel_a  = gnt_port ? req_a1  : req_a0;
    assign sel_b  = gnt_port ? req_b1  : req_b0;

    alu #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            rsp_valid_q <= 2'b00;
            result_q    <= '0;
            zero_q      <= 1'b1;
`ifdef ALU_ARB_RR_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!gnt_valid && rsp_ready[owner_q]) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (gnt_valid) begin
                owner_q     <= gnt_port;
                result_q    <= alu_result;
                zero_q      <= (alu_result == '0);
                rsp_valid_q <= port_onehot(gnt_port);
`ifdef ALU_ARB_RR_EN
                rr_ptr_q    <= ~gnt_port;
`endif
            end else if (state_q == ST_BUSY && rsp_ready[owner_q]) begin
                rsp_valid_q <= 2'b00;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares one ALU instance between two requesters: port 0 is the execute stage and port 1 is the branch/address unit. Each port has a valid/ready request channel and a valid/ready response channel. The block arbitrates between the ports, registers one result, and holds that result until its owner accepts it. It sits between the decode-side alu_op generation and the ALU datapath, so a single 4-bit-op ALU serves both consumers.

## Interface
- XLEN, 32: operand/result width; must be a power of two ≥ 8.
- SHW, $clog2(XLEN): shift-amount width taken from operand b.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid[1:0]  in  2  per-port request valid.
- req_ready[1:0]  out  2  per-port request accepted this cycle when valid & ready.
- req_op0, req_op1  in  4 each  ALU operation code (shared ALU_* codes).
- req_a0, req_b0, req_a1, req_b1  in  XLEN each  operands.
- rsp_valid[1:0]  out  2  result available for the port.
- rsp_ready[1:0]  in  2  port consumes the result.
- rsp_result  out  XLEN  registered result (owner given by rsp_valid).
- rsp_zero  out  1  rsp_result == 0, for branch compare via ALU_SUB.

## Operation
- FSM states:
  - IDLE: result slot empty.
  - BUSY: result slot full; owner recorded in `owner`.
- IDLE → BUSY on any grant.
- BUSY → IDLE when the owner's rsp_ready is high and no new grant occurs.
- BUSY → BUSY when the owner drains and a new grant occurs in the same cycle (back-to-back).
- Slot is free when state == IDLE, or state == BUSY and rsp_ready[owner] is high.
- Grant only when the slot is free; at most one grant per cycle; req_ready is set only for the granted port.
- req_ready is combinational from req_valid, rsp_ready, state, and the priority pointer. Requesters must not make req_valid depend on req_ready.
- Arbitration when both ports are valid is set by the macro (see Configuration). Single valid port: granted if the slot is free.
- ALU semantics, all results XLEN wide:
  - ADD/SUB wrap mod 2^XLEN.
  - SLL/SRL shift by b[SHW-1:0]. SRL is logical, including the SRA-mapped encodings.
  - SLT is signed compare and SLTU unsigned, each giving 1 or 0.
  - XOR/OR/AND are bitwise.
  - Undefined op codes give 0.
- On grant, the result and owner are captured; rsp_valid[owner] = 1 and the other bit = 0.
- If rsp_ready arrives for the non-owner port, it is ignored.
- A requester's operands need only be stable in the accept cycle.

## Timing
- Reset values:
  - state IDLE, owner 0, rr_ptr 0 (port 0 preferred first).
  - rsp_valid 2'b00, rsp_result 0, rsp_zero 1.
  - req_ready 2'b00 while rst_n is low.
- Latency: accept in cycle N → rsp_valid in cycle N+1.
- Throughput: one operation per cycle when the owner holds rsp_ready high.
- A stalled response (rsp_ready low) blocks both ports; req_ready = 00 until it drains.
- Reset mid-operation: the held result is discarded immediately (async) and the block returns to IDLE.
- A request held valid and ungranted must stay valid with stable op/operands until accepted.

## Configuration
- ALU_ARB_RR_EN defined:
  - Round-robin arbitration. rr_ptr names the preferred port and flips to the non-granted port after each grant.
  - With both ports continuously valid, grants alternate 0,1,0,1…
- Not defined:
  - Fixed priority with port 0 always winning; rr_ptr is removed.
  - Port 1 may starve under continuous port-0 traffic (accepted).

## Structure
- Shared package (alu_pkg):
  - ALU_* op-code constants (4-bit), which must match the codes used by alu_op generation.
  - FSM state typedef.
- Sub-module: alu, purely combinational (op, a, b → result), instantiated once.
- The arbiter, FSM and result register are in alu_share_arb.

## Test plan
- Reset, then port 0 ADD 5+7 with rsp_ready0 = 1:
  - rsp_valid = 01 one cycle after accept, rsp_result = 12, rsp_zero = 0.
- Port 1 SUB 9−9, then SLT 0xFFFFFFFF<1 and SLTU 0xFFFFFFFF<1:
  - Results 0 with rsp_zero = 1, then 1, then 0.
- Both ports valid every cycle with rsp_ready = 11:
  - With ALU_ARB_RR_EN: grants alternate starting at port 0, one result per cycle.
  - Without it: port 0 only and req_ready1 stays low.
- Port 0 result held with rsp_ready0 = 0 for 3 cycles while port 1 is valid:
  - req_ready = 00 and rsp_result stable.
  - Port 1 is granted in the cycle rsp_ready0 rises; its result appears the next cycle.
- SLL 1<<31 → 0x80000000; SRL 0x80000000>>35 → 0x10000000 (shift masked to 3); undefined op 4'hF → 0.
- rst_n pulsed low while BUSY: rsp_valid drops to 00 asynchronously, and the next request behaves as after a fresh reset.
